// File: rtl/act_quant_packer.sv
// rtl/act_quant_packer.sv - FP32 -> INT8 power-of-two quantizer packing 16-element tiles into 128-bit memory words.
// Optional saturation statistics (sat_count port) enabled by defining ACT_QUANT_STATS_EN.
module act_quant_packer #(
  parameter int WORDS       = 32,
  parameter int SCALE_SHIFT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  output logic         busy,
  output logic         done,
  output logic         MEM_CEB,
  output logic         MEM_WEN,
  output logic [4:0]   MEM_ADDR,
  output logic [127:0] MEM_DIN
`ifdef ACT_QUANT_STATS_EN
  ,
  output logic [9:0]   sat_count
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [4:0] LAST_ADDR = 5'(WORDS - 1);

  logic [1:0]   state;
  logic [3:0]   k;
  logic [127:0] pack;
  logic         hs;

  logic [7:0]   exp_f;
  logic [22:0]  frac;
  logic         neg;
  logic [25:0]  mant;
  logic [25:0]  rnd;
  int           esh;
  int           rsh;
  logic         q_sat;
  logic [7:0]   q_val;

  assign in_ready = (state == S_FILL);
  assign hs       = in_valid & in_ready;

  assign neg   = in_data[31];
  assign exp_f = in_data[30:23];
  assign frac  = in_data[22:0];
  assign mant  = {2'b00, 1'b1, frac};

  // Scaled value is mant * 2^esh; a non-negative esh already exceeds 127.
  always_comb begin
    q_sat = 1'b0;
    rnd   = '0;
    esh   = 0;
    rsh   = 0;
    if (exp_f == 8'd255) begin
      q_sat = (frac == 23'd0);
    end else if (exp_f != 8'd0) begin
      esh = int'(exp_f) + SCALE_SHIFT - 150;
      if (esh >= 0) begin
        q_sat = 1'b1;
      end else begin
        rsh = -esh;
        if (rsh <= 25) begin
          rnd = (mant + (26'd1 << (rsh - 1))) >> rsh;
        end
        q_sat = neg ? (rnd > 26'd128) : (rnd > 26'd127);
      end
    end
    if (q_sat) begin
      q_val = neg ? 8'h80 : 8'h7F;
    end else begin
      q_val = neg ? (8'd0 - rnd[7:0]) : rnd[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      k        <= 4'd0;
      pack     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      MEM_CEB  <= 1'b1;
      MEM_WEN  <= 1'b1;
      MEM_ADDR <= 5'd0;
      MEM_DIN  <= '0;
    end else begin
      done    <= 1'b0;
      MEM_CEB <= 1'b1;
      MEM_WEN <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FILL;
            busy     <= 1'b1;
            k        <= 4'd0;
            MEM_ADDR <= 5'd0;
          end
        end
        S_FILL: begin
          if (hs) begin
            pack[{k, 3'b000} +: 8] <= q_val;
            k <= k + 4'd1;
            if (k == 4'd15) begin
              state   <= S_WRITE;
              MEM_CEB <= 1'b0;
              MEM_WEN <= 1'b0;
              MEM_DIN <= {q_val, pack[119:0]};
            end
          end
        end
        S_WRITE: begin
          k <= 4'd0;
          if (MEM_ADDR == LAST_ADDR) begin
            state    <= S_DONE;
            done     <= 1'b1;
            MEM_ADDR <= 5'd0;
          end else begin
            state    <= S_FILL;
            MEM_ADDR <= MEM_ADDR + 5'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACT_QUANT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= 10'd0;
    end else if (state == S_IDLE && start) begin
      sat_count <= 10'd0;
    end else if (hs && q_sat && sat_count != 10'h3FF) begin
      sat_count <= sat_count + 10'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_quant_packer.sv
// tb/tb_act_quant_packer.sv - randomized self-checking bench for act_quant_packer against a real-arithmetic model.
module tb_act_quant_packer;
  localparam int WORDS = 32;
  localparam int SHIFT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = 32'd0;
  logic         in_ready, busy, done, MEM_CEB, MEM_WEN;
  logic [4:0]   MEM_ADDR;
  logic [127:0] MEM_DIN;
`ifdef ACT_QUANT_STATS_EN
  logic [9:0]   sat_count;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int proto_bad = 0;
  logic prev_done = 1'b0;
  logic [4:0]   wr_addr[$];
  logic [127:0] wr_data[$];
  int           wr_cyc[$];
  int           done_cyc[$];

  act_quant_packer #(.WORDS(WORDS), .SCALE_SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .MEM_CEB(MEM_CEB), .MEM_WEN(MEM_WEN),
    .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN)
`ifdef ACT_QUANT_STATS_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!MEM_CEB) begin
        wr_addr.push_back(MEM_ADDR);
        wr_data.push_back(MEM_DIN);
        wr_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (MEM_CEB !== MEM_WEN) proto_bad++;
      if (!busy && !MEM_CEB) proto_bad++;
      if (busy && !done && (in_ready == !MEM_CEB)) proto_bad++;
      if (prev_done && busy) proto_bad++;
      prev_done = done;
    end
  end

  // Rounded scaled value, clamped to +-1000 so saturation is visible as out of [-128,127].
  function automatic int ref_val(input logic [31:0] x);
    int e;
    real mag;
    int r;
    e = int'(x[30:23]);
    if (e == 0) return 0;
    if (e == 255) return (x[22:0] != 23'd0) ? 0 : (x[31] ? -1000 : 1000);
    mag = (real'(x[22:0]) + 8388608.0) * (2.0 ** real'(e - 150 + SHIFT));
    r = (mag >= 1000.0) ? 1000 : int'($floor(mag + 0.5));
    return x[31] ? -r : r;
  endfunction

  function automatic logic [7:0] ref_byte(input int v);
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  function automatic logic [31:0] rand_elem();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0: return $urandom;
      1: return {s, 31'h7F800000};
      2: return {s, 8'd0, 23'($urandom)};
      3: return {s, 8'hFF, 23'($urandom) | 23'd1};
      4: return {s, 8'($urandom_range(119, 130)), 23'($urandom) & 23'h7F0000};
      default: return {s, 8'($urandom_range(115, 134)), 23'($urandom)};
    endcase
  endfunction

  task automatic model_frame(input logic [31:0] el[$], output logic [127:0] w[$], output int sats);
    logic [127:0] cur;
    int v;
    w = {};
    sats = 0;
    cur = '0;
    for (int i = 0; i < el.size(); i++) begin
      v = ref_val(el[i]);
      cur[(i % 16) * 8 +: 8] = ref_byte(v);
      if (i % 16 == 15) w.push_back(cur);
      if (v > 127 || v < -128) sats++;
    end
    if (sats > 1023) sats = 1023;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    proto_bad = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h42C80000;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] el[$], input bit toggle, input bit midstart, output int got);
    int budget;
    bit hs;
    bit pulsed;
    budget = 0;
    pulsed = 0;
    got = 0;
    while (got < el.size() && budget < 4000) begin
      @(negedge clk);
      in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = in_valid ? el[got] : $urandom;
      start = midstart && !pulsed && got == 200;
      if (start) pulsed = 1;
      #1 hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) got++;
      budget++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 60 && done_cyc.size() == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, busy, done, MEM_CEB, MEM_WEN, MEM_ADDR} !== {5'b00011, 5'd0}) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=%b", {in_ready, busy, done, MEM_CEB, MEM_WEN, MEM_ADDR}, {5'b00011, 5'd0});
    end
    total++;
    if (MEM_DIN !== 128'd0) begin bad++; $display("FAIL reset_din got=%h want=0", MEM_DIN); end
`ifdef ACT_QUANT_STATS_EN
    total++;
    if (sat_count !== 10'd0) begin bad++; $display("FAIL reset_sat got=%0d want=0", sat_count); end
`endif
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_accept in_ready=%b busy=%b want 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] el[$];
    logic [127:0] w[$];
    logic [31:0] dir[16] = '{32'hBF800000, 32'h3D000000, 32'hBD000000, 32'h42C80000,
                             32'hC2C80000, 32'h7F800000, 32'h7FC00000, 32'h00000001,
                             32'hFF800000, 32'h80000000, 32'h41000000, 32'hC1000000,
                             32'h40FF0000, 32'hC0FF0000, 32'h3FC00000, 32'h3E900000};
    int sats;
    int got;
    for (int i = 0; i < 16; i++) el.push_back(32'h3F800000);
    for (int i = 0; i < 16; i++) el.push_back(dir[i]);
    for (int i = 32; i < 16 * WORDS; i++) el.push_back(rand_elem());
    model_frame(el, w, sats);
    clear_mon();
    do_start();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_start got=%b want=1", in_ready); end
    feed(el, 1'b0, 1'b0, got);
    wait_done();
    total++;
    if (got != el.size() || wr_data.size() != WORDS) begin
      bad++;
      $display("FAIL dir_count accepted=%0d writes=%0d want %0d %0d", got, wr_data.size(), el.size(), WORDS);
    end
    total++;
    if (wr_data.size() < 1 || wr_addr[0] !== 5'd0 || wr_data[0] !== {16{8'h10}}) begin
      bad++;
      $display("FAIL dir_word0 got=%h want=%h", (wr_data.size() > 0) ? wr_data[0] : 128'hx, {16{8'h10}});
    end
    total++;
    if (wr_data.size() < 2 || wr_data[1] !== 128'h0518807F807F008000007F807FFF01F0) begin
      bad++;
      $display("FAIL dir_word1 got=%h want=%h", (wr_data.size() > 1) ? wr_data[1] : 128'hx, 128'h0518807F807F008000007F807FFF01F0);
    end
    for (int i = 0; i < WORDS && i < wr_data.size(); i++) begin
      total++;
      if (wr_addr[i] !== 5'(i) || wr_data[i] !== w[i]) begin
        bad++;
        $display("FAIL dir_word[%0d] addr=%0d data=%h want addr=%0d data=%h", i, wr_addr[i], wr_data[i], i, w[i]);
      end
    end
    total++;
    if (wr_cyc.size() < 2 || wr_cyc[1] - wr_cyc[0] != 17) begin
      bad++;
      $display("FAIL dir_throughput spacing=%0d want=17", (wr_cyc.size() > 1) ? wr_cyc[1] - wr_cyc[0] : -1);
    end
    total++;
    if (done_cyc.size() != 1 || wr_cyc.size() != WORDS || done_cyc[0] != wr_cyc[WORDS - 1] + 1) begin
      bad++;
      $display("FAIL dir_done_timing done_pulses=%0d done_at=%0d want one pulse 1 cycle after last write", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    total++;
    if (proto_bad != 0) begin bad++; $display("FAIL dir_protocol errors=%0d want=0", proto_bad); end
`ifdef ACT_QUANT_STATS_EN
    total++;
    if (sat_count !== 10'(sats)) begin bad++; $display("FAIL dir_sat got=%0d want=%0d", sat_count, sats); end
`endif
  endtask

  task automatic test_random_toggle();
    logic [31:0] el[$];
    logic [127:0] w[$];
    int sats;
    int got;
    for (int i = 0; i < 16 * WORDS; i++) el.push_back(rand_elem());
    model_frame(el, w, sats);
    clear_mon();
    do_start();
    feed(el, 1'b1, 1'b1, got);
    wait_done();
    total++;
    if (got != el.size() || wr_data.size() != WORDS) begin
      bad++;
      $display("FAIL tog_count accepted=%0d writes=%0d want %0d %0d", got, wr_data.size(), el.size(), WORDS);
    end
    for (int i = 0; i < WORDS && i < wr_data.size(); i++) begin
      total++;
      if (wr_addr[i] !== 5'(i) || wr_data[i] !== w[i]) begin
        bad++;
        $display("FAIL tog_word[%0d] addr=%0d data=%h want addr=%0d data=%h", i, wr_addr[i], wr_data[i], i, w[i]);
      end
    end
    total++;
    if (done_cyc.size() != 1 || wr_cyc.size() != WORDS || done_cyc[0] != wr_cyc[WORDS - 1] + 1) begin
      bad++;
      $display("FAIL tog_done_timing done_pulses=%0d want one pulse 1 cycle after last write", done_cyc.size());
    end
    total++;
    if (proto_bad != 0) begin bad++; $display("FAIL tog_protocol errors=%0d want=0", proto_bad); end
`ifdef ACT_QUANT_STATS_EN
    total++;
    if (sat_count !== 10'(sats)) begin bad++; $display("FAIL tog_sat got=%0d want=%0d", sat_count, sats); end
`endif
  endtask

  task automatic test_reset_midframe();
    logic [31:0] el[$];
    logic [127:0] w[$];
    int sats;
    int got;
    for (int i = 0; i < 39; i++) el.push_back(rand_elem());
    model_frame(el, w, sats);
    clear_mon();
    do_start();
    feed(el, 1'b0, 1'b0, got);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, done, MEM_CEB, MEM_WEN, MEM_ADDR} !== {5'b00011, 5'd0} || MEM_DIN !== 128'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs ctrl=%b din=%h want ctrl=%b din=0", {in_ready, busy, done, MEM_CEB, MEM_WEN, MEM_ADDR}, MEM_DIN, {5'b00011, 5'd0});
    end
`ifdef ACT_QUANT_STATS_EN
    total++;
    if (sat_count !== 10'd0) begin bad++; $display("FAIL mid_reset_sat got=%0d want=0", sat_count); end
`endif
    repeat (4) @(negedge clk);
    total++;
    if (wr_data.size() != 2 || wr_data[0] !== w[0] || wr_data[1] !== w[1] || wr_addr[1] !== 5'd1) begin
      bad++;
      $display("FAIL mid_partial_writes writes=%0d want=2 with first two words intact", wr_data.size());
    end
    rst_n = 1'b1;
    el = {};
    for (int i = 0; i < 16 * WORDS; i++) el.push_back(rand_elem());
    model_frame(el, w, sats);
    clear_mon();
    do_start();
    feed(el, 1'b0, 1'b0, got);
    wait_done();
    total++;
    if (wr_data.size() != WORDS) begin bad++; $display("FAIL restart_count writes=%0d want=%0d", wr_data.size(), WORDS); end
    for (int i = 0; i < WORDS && i < wr_data.size(); i++) begin
      total++;
      if (wr_addr[i] !== 5'(i) || wr_data[i] !== w[i]) begin
        bad++;
        $display("FAIL restart_word[%0d] addr=%0d data=%h want addr=%0d data=%h", i, wr_addr[i], wr_data[i], i, w[i]);
      end
    end
`ifdef ACT_QUANT_STATS_EN
    total++;
    if (sat_count !== 10'(sats)) begin bad++; $display("FAIL restart_sat got=%0d want=%0d", sat_count, sats); end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_toggle();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
